// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the CRC-32 FCS engine.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/crc_step.sv
// Combinational reflected CRC update over one DATA_W-bit beat, LSB first.
module crc_step #(
  parameter int          DATA_W   = 4,
  parameter logic [31:0] CRC_POLY = crc_pkg::CRC32_POLY
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_next
);

  logic [31:0] c;

  always_comb begin
    // NOTE: blocking assignments chain each bit's result into the next bit within the same cycle.
    c = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_fcs_engine.sv
// Streaming CRC-32 engine: TX appends the FCS after the frame, RX checks the residue.
module crc_fcs_engine
  import crc_pkg::*;
#(
  parameter int          DATA_W      = 4,
  parameter logic [31:0] CRC_POLY    = CRC32_POLY,
  parameter logic [31:0] CRC_INIT    = CRC32_INIT,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              append,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [31:0]       crc_out,
  output logic              crc_ok,
  output logic              done
);

  localparam int N     = 32 / DATA_W;
  localparam int CNT_W = $clog2(N);

  state_t            state;
  logic [31:0]       crc_reg;
  logic [31:0]       crc_seed;
  logic [31:0]       crc_next;
  logic [31:0]       fcs;
  logic              tx_mode;
  logic              frame_tx;
  logic              accept;
  logic [CNT_W-1:0]  cnt;

  assign accept   = in_valid && in_ready;
  // A beat taken in IDLE opens a new frame, so it never sees the previous frame's register.
  assign crc_seed = (state == IDLE) ? CRC_INIT : crc_reg;
  assign frame_tx = (state == IDLE) ? append : tx_mode;
  assign fcs      = ~crc_reg;

  crc_step #(
    .DATA_W   (DATA_W),
    .CRC_POLY (CRC_POLY)
  ) u_step (
    .crc_in   (crc_seed),
    .data     (in_data),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc_reg   <= CRC_INIT;
      tx_mode   <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, BUSY: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            crc_reg   <= crc_next;
            if (state == IDLE) begin
              tx_mode <= append;
              crc_out <= '0;
              crc_ok  <= 1'b0;
            end
            if (!in_last) begin
              state <= BUSY;
            end else if (frame_tx) begin
              state    <= EMIT;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              state    <= IDLE;
              out_last <= 1'b1;
              done     <= 1'b1;
              crc_out  <= ~crc_next;
              crc_ok   <= (crc_next == CRC_RESIDUE);
            end
          end
        end
        EMIT: begin
          out_valid <= 1'b1;
          out_data  <= fcs[cnt*DATA_W +: DATA_W];
          if (cnt == CNT_W'(N - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b1;
            out_last <= 1'b1;
            done     <= 1'b1;
            crc_out  <= fcs;
            crc_ok   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_fcs_engine.sv
// Randomised self-checking bench: two engine instances (8-bit and 4-bit beats) against a frame-level model.
module tb_crc_fcs_engine;

  typedef byte unsigned byte_q_t[$];
  typedef bit           bit_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-frame CRC register value, bit-serial from the all-ones start value.
  function automatic logic [31:0] crc_reg_of(input bit_q_t bits);
    logic [31:0] r = 32'hFFFFFFFF;
    foreach (bits[i]) r = (r[0] ^ bits[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic bit_q_t bits_of(input byte_q_t bytes);
    bit_q_t q;
    foreach (bytes[i]) for (int b = 0; b < 8; b++) q.push_back(bytes[i][b]);
    return q;
  endfunction

  byte_q_t s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int DW = (g == 0) ? 8 : 4;
    localparam int NB = 32 / DW;
    typedef logic [DW-1:0] beat_t;
    typedef beat_t beat_q_t[$];
    typedef struct {
      bit          valid;
      beat_t       data;
      bit          last;
      bit          done;
      bit          clr;
      logic [31:0] crc;
      bit          ok;
    } rec_t;

    logic        rst = 1'b1;
    logic        append = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    beat_t       in_data = '0;
    logic        in_ready, out_valid, out_last, crc_ok, done;
    beat_t       out_data;
    logic [31:0] crc_out;
    bit          fin = 1'b0;

    crc_fcs_engine #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .append    (append),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .crc_out   (crc_out),
      .crc_ok    (crc_ok),
      .done      (done)
    );

    rec_t        out_q[$];
    bit          frame_bits[$];
    bit          frame_open = 1'b0;
    bit          frame_tx = 1'b0;
    logic [31:0] held_crc = '0;
    bit          held_ok = 1'b0;
    beat_t       cap_q[$];
    int          ready_low = 0;

    task automatic lc(input string n, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("w%0d %s", DW, n), act, exp);
    endtask

    // Model: every accepted beat schedules its future output cycles into out_q.
    always @(negedge clk) begin
      rec_t        cur, r, f;
      bit          exp_ready;
      logic [31:0] reg_v;
      if (rst) begin
        lc("rst out_valid", out_valid, 0);
        lc("rst out_last",  out_last,  0);
        lc("rst done",      done,      0);
        lc("rst out_data",  out_data,  0);
        lc("rst crc_out",   crc_out,   0);
        lc("rst crc_ok",    crc_ok,    0);
        lc("rst in_ready",  in_ready,  1);
        out_q.delete();
        frame_bits.delete();
        frame_open = 1'b0;
        held_crc   = '0;
        held_ok    = 1'b0;
      end else begin
        cur = '{default: 0};
        if (out_q.size() > 0) cur = out_q.pop_front();
        if (cur.clr) begin held_crc = '0; held_ok = 1'b0; end
        if (cur.done) begin held_crc = cur.crc; held_ok = cur.ok; end
        exp_ready = (out_q.size() == 0);
        lc("out_valid", out_valid, cur.valid);
        lc("out_last",  out_last,  cur.last);
        lc("done",      done,      cur.done);
        lc("in_ready",  in_ready,  exp_ready);
        lc("crc_out",   crc_out,   held_crc);
        lc("crc_ok",    crc_ok,    held_ok);
        if (cur.valid) lc("out_data", out_data, cur.data);
        if (out_valid) cap_q.push_back(out_data);
        if (!in_ready) ready_low++;
        if (in_valid && exp_ready) begin
          r = '{default: 0};
          r.valid = 1'b1;
          r.data  = in_data;
          if (!frame_open) begin
            frame_open = 1'b1;
            frame_tx   = append;
            r.clr      = 1'b1;
          end
          for (int i = 0; i < DW; i++) frame_bits.push_back(in_data[i]);
          if (in_last) begin
            reg_v = crc_reg_of(frame_bits);
            frame_bits.delete();
            frame_open = 1'b0;
            if (frame_tx) begin
              out_q.push_back(r);
              for (int k = 0; k < NB; k++) begin
                f = '{default: 0};
                f.valid = 1'b1;
                f.data  = beat_t'((~reg_v) >> (k * DW));
                f.last  = (k == NB - 1);
                f.done  = (k == NB - 1);
                f.crc   = ~reg_v;
                out_q.push_back(f);
              end
            end else begin
              r.last = 1'b1;
              r.done = 1'b1;
              r.crc  = ~reg_v;
              r.ok   = (reg_v == 32'hDEBB20E3);
              out_q.push_back(r);
            end
          end else begin
            out_q.push_back(r);
          end
        end
      end
    end

    function automatic beat_q_t to_beats(input byte_q_t bytes);
      beat_q_t q;
      foreach (bytes[i]) for (int s = 0; s < 8; s += DW) q.push_back(beat_t'(bytes[i] >> s));
      return q;
    endfunction

    task automatic send(input beat_q_t beats, input bit app, input bit use_last, input int gap_pct);
      for (int i = 0; i < beats.size(); i++) begin
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = beats[i];
        in_last  = use_last && (i == beats.size() - 1);
        append   = app;
        for (int w = 0; w < 200 && !acc; w++) begin
          @(negedge clk);
          acc = in_ready;
          @(posedge clk);
          #1;
        end
        lc("beat accepted", acc, 1);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          in_valid = 1'b0;
          in_data  = beat_t'($urandom);
          in_last  = 1'($urandom_range(1));
          append   = 1'($urandom_range(1));
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
      bit got = 1'b0;
      lat = -1;
      for (int w = 0; w < 64 && !got; w++) begin
        @(negedge clk);
        if (done) begin got = 1'b1; lat = w; end
      end
      lc("done seen", got, 1);
      @(posedge clk);
      #1;
    endtask

    task automatic pulse_rst();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    endtask

    initial begin
      int          lat, n_done;
      byte_q_t     good, bad, rb;
      logic [31:0] fcs_cat, c;
      beat_q_t     bq;

      lc("model pin 123456789", ~crc_reg_of(bits_of(s9)), 32'hCBF43926);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      send(to_beats(s9), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("rx latency", lat, 0);
      lc("rx crc_out", crc_out, 32'hCBF43926);
      lc("rx crc_ok", crc_ok, 0);

      ready_low = 0;
      cap_q.delete();
      send(to_beats(s9), 1'b1, 1'b1, 0);
      wait_done(lat);
      lc("tx done latency", lat, NB);
      lc("tx ready low cycles", ready_low, NB);
      fcs_cat = '0;
      for (int k = 0; k < NB; k++)
        fcs_cat |= 32'(cap_q[cap_q.size() - NB + k]) << (k * DW);
      lc("tx fcs beats", fcs_cat, 32'hCBF43926);
      lc("tx crc_out", crc_out, 32'hCBF43926);
      lc("tx crc_ok", crc_ok, 0);

      good = s9;
      good.push_back(8'h26); good.push_back(8'h39); good.push_back(8'hF4); good.push_back(8'hCB);
      send(to_beats(good), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("rx good crc_ok", crc_ok, 1);
      lc("rx good crc_out", crc_out, 32'h2144DF1C);
      bad = good;
      bad[3] = bad[3] ^ 8'h01;
      send(to_beats(bad), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("rx bad crc_ok", crc_ok, 0);

      send(to_beats(s9), 1'b0, 1'b1, 0);
      send(to_beats(s9), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("b2b second crc_out", crc_out, 32'hCBF43926);

      send(to_beats(s9), 1'b1, 1'b1, 0);
      send(to_beats(s9), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("after emit crc_out", crc_out, 32'hCBF43926);

      bq = to_beats(s9);
      bq = bq[0:2];
      send(bq, 1'b0, 1'b0, 0);
      pulse_rst();
      send(to_beats(s9), 1'b0, 1'b1, 0);
      wait_done(lat);
      lc("post-rst crc_out", crc_out, 32'hCBF43926);

      send(to_beats(s9), 1'b1, 1'b1, 0);
      repeat (2) @(posedge clk);
      pulse_rst();
      n_done = 0;
      for (int w = 0; w < 12; w++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      lc("no done after emit rst", n_done, 0);
      @(posedge clk);
      #1;

      for (int fr = 0; fr < 40; fr++) begin
        if ($urandom_range(3) == 0) begin
          rb.delete();
          repeat ($urandom_range(1, 8)) rb.push_back(8'($urandom));
          c = ~crc_reg_of(bits_of(rb));
          for (int k = 0; k < 4; k++) rb.push_back(c[8*k +: 8]);
          send(to_beats(rb), 1'b0, 1'b1, 30);
        end else begin
          bq.delete();
          repeat ($urandom_range(1, 20)) bq.push_back(beat_t'($urandom));
          send(bq, 1'($urandom_range(1)), 1'b1, $urandom_range(1) ? 30 : 0);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      repeat (NB + 4) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    bit all_fin = 1'b0;
    for (int c = 0; c < 50000 && !all_fin; c++) begin
      @(posedge clk);
      all_fin = lane[0].fin && lane[1].fin;
    end
    check("lanes finished", {30'd0, lane[1].fin, lane[0].fin}, 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
